// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and sizing for the time-multiplexed FIR filter.
// The default N/NTAPS values match the existing delay-chain filter.
package fir_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} fir_state_t;

  localparam int N_DEF     = 32;
  localparam int NTAPS_DEF = 8;

  // Wide enough to hold NTAPS full-scale products without overflow.
  function automatic int acc_width(input int n, input int ntaps);
    return 2 * n + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac.sv
// Shared signed multiply-accumulate for the FIR sequencer.
// This is the only multiplier in the filter.
module fir_mac
  import fir_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = acc_width(N_DEF, NTAPS_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    clr,
  input  logic                    en_acc,
  input  logic signed [N-1:0]     a,
  input  logic signed [N-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*N-1:0] prod;

  assign prod = (2*N)'(a) * (2*N)'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (ena) begin
      if (clr)
        acc <= '0;
      else if (en_acc)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks NTAPS taps per accepted sample.
// Define FIR_SAT_EN to clamp y_out to the N-bit signed range instead of wrapping.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic signed [N-1:0]        x_in,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic signed [N-1:0]        y_out,
  output logic                       y_valid,
  input  logic                       y_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [N-1:0]        coef_data,
  output logic                       busy
);

  localparam int ACC_W = acc_width(N, NTAPS);
  localparam int AW    = $clog2(NTAPS);

  fir_state_t              state;
  logic [AW-1:0]           head;
  logic [AW-1:0]           tap;
  logic [AW-1:0]           head_nxt;
  logic [AW-1:0]           rd_idx;
  logic signed [N-1:0]     hist [NTAPS];
  logic signed [N-1:0]     coef [NTAPS];
  logic signed [ACC_W-1:0] acc;
  logic                    accept;
  logic                    coef_ok;

  function automatic logic signed [N-1:0] out_fn(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'({1'b0, {(N-1){1'b1}}});
    lo = -hi - 1;
    if (a > hi)
      return N'(hi);
    else if (a < lo)
      return N'(lo);
    else
      return N'(a);
`else
    return N'(a);
`endif
  endfunction

  assign x_ready  = (state == S_IDLE) & ena;
  assign accept   = x_ready & x_valid;
  assign coef_ok  = x_ready & coef_we & (int'(coef_addr) < NTAPS);
  assign head_nxt = (int'(head) == NTAPS - 1) ? '0 : head + 1'b1;

  // Circular read pointer: newest sample first, walking back in time.
  always_comb begin
    rd_idx = head - tap;
    if (head < tap)
      rd_idx = AW'(int'(head) + NTAPS - int'(tap));
  end

  fir_mac #(.N(N), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .clr    (accept),
    .en_acc (state == S_MAC),
    .a      (coef[tap]),
    .b      (hist[rd_idx]),
    .acc    (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      head    <= '0;
      tap     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else if (ena) begin
      if (coef_ok)
        coef[coef_addr] <= coef_data;
      case (state)
        S_IDLE: begin
          if (x_valid) begin
            head           <= head_nxt;
            hist[head_nxt] <= x_in;
            tap            <= '0;
            busy           <= 1'b1;
            state          <= S_MAC;
          end
        end
        S_MAC: begin
          if (int'(tap) == NTAPS - 1)
            state <= S_OUT;
          else
            tap <= tap + 1'b1;
        end
        S_OUT: begin
          // First OUT cycle captures the settled accumulator; then wait for the consumer.
          if (!y_valid) begin
            y_out   <= out_fn(acc);
            y_valid <= 1'b1;
          end else if (y_ready) begin
            y_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a sum-of-products reference model.
module tb_fir_mac_sequencer;

  localparam int N     = 32;
  localparam int NTAPS = 8;
  localparam logic signed [N-1:0] MAXV = 32'sh7FFF_FFFF;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     ena = 1'b1;
  logic signed [N-1:0]      x_in = '0;
  logic                     x_valid = 1'b0;
  logic                     x_ready;
  logic signed [N-1:0]      y_out;
  logic                     y_valid;
  logic                     y_ready = 1'b1;
  logic                     coef_we = 1'b0;
  logic [$clog2(NTAPS)-1:0] coef_addr = '0;
  logic signed [N-1:0]      coef_data = '0;
  logic                     busy;

  fir_mac_sequencer #(.N(N), .NTAPS(NTAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: mh[0] is the newest sample x[n].
  logic signed [N-1:0] mb [NTAPS];
  logic signed [N-1:0] mh [NTAPS];
  logic signed [N-1:0] exp_y = '0;
  logic signed [N-1:0] last_y = '0;
  logic                pending = 1'b0;
  logic                exp_vld;
  logic                prev_vld = 1'b0;
  int                  cnt = 0;
  int                  cyc = 0;
  int                  acc_cyc = 0;
  int                  lat = -1;
  logic signed [N-1:0] got [$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [N-1:0] model_y();
    logic signed [127:0] s;
    logic signed [127:0] a;
    logic signed [127:0] b;
    logic signed [127:0] hi;
    s = '0;
    for (int k = 0; k < NTAPS; k++) begin
      a = mb[k];
      b = mh[k];
      s = s + a * b;
    end
`ifdef FIR_SAT_EN
    hi = MAXV;
    if (s > hi) s = hi;
    else if (s < -hi - 1) s = -hi - 1;
`else
    hi = '0;
`endif
    return s[N-1:0];
  endfunction

  // Compare process: outputs are checked every cycle; then the model applies the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_y_valid", 64'(y_valid), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_y_out", y_out, 0);
      for (int k = 0; k < NTAPS; k++) begin
        mb[k] = '0;
        mh[k] = '0;
      end
      pending = 1'b0;
      cnt = 0;
      last_y = '0;
      prev_vld = 1'b0;
    end else begin
      exp_vld = pending && (cnt >= NTAPS + 1);
      check("x_ready", 64'(x_ready), 64'(ena && !pending));
      check("busy", 64'(busy), 64'(pending));
      check("y_valid", 64'(y_valid), 64'(exp_vld));
      check("y_out", y_out, exp_vld ? exp_y : last_y);
      if (y_valid && !prev_vld) lat = cyc - acc_cyc - 1;
      prev_vld = y_valid;
      if (ena) begin
        if (!pending) begin
          if (coef_we && int'(coef_addr) < NTAPS) mb[coef_addr] = coef_data;
          if (x_valid) begin
            for (int k = NTAPS - 1; k > 0; k--) mh[k] = mh[k-1];
            mh[0] = x_in;
            exp_y = model_y();
            pending = 1'b1;
            cnt = 0;
            acc_cyc = cyc;
          end
        end else if (exp_vld) begin
          if (y_ready) begin
            got.push_back(y_out);
            last_y = exp_y;
            pending = 1'b0;
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wcoef(input int a, input logic signed [N-1:0] d);
    coef_we = 1'b1;
    coef_addr = a[$clog2(NTAPS)-1:0];
    coef_data = d;
    step();
    coef_we = 1'b0;
  endtask

  task automatic all_coef(input logic signed [N-1:0] d);
    for (int k = 0; k < NTAPS; k++) wcoef(k, d);
  endtask

  task automatic send(input logic signed [N-1:0] x);
    int n;
    n = 0;
    x_in = x;
    x_valid = 1'b1;
    while (!(x_ready && ena) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      miscompares++;
      $display("FAIL send_timeout: got no x_ready expected x_ready within 500 cycles");
    end
    step();
    x_valid = 1'b0;
  endtask

  task automatic wait_outs(input int k);
    int n;
    n = 0;
    while (got.size() < k && n < 2000) begin
      step();
      n++;
    end
    if (got.size() < k) begin
      miscompares++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", got.size(), k);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic signed [N-1:0] exp);
    logic signed [N-1:0] v;
    v = (idx < got.size()) ? got[idx] : 'x;
    check(name, v, exp);
  endtask

  initial begin
    int n;
    logic signed [N-1:0] y0;
    do_reset();
    check("reset_x_ready", 64'(x_ready), 1);
    check("reset_y_valid", 64'(y_valid), 0);

    // Impulse response
    for (int k = 0; k < NTAPS; k++) wcoef(k, 32'(k + 1));
    got.delete();
    send(1);
    for (int i = 0; i < NTAPS - 1; i++) send(0);
    wait_outs(NTAPS);
    for (int i = 0; i < NTAPS; i++) check_got("impulse", i, 32'(i + 1));
    check("impulse_latency", lat, NTAPS + 1);

    // Step response through history wrap
    do_reset();
    all_coef(1);
    got.delete();
    for (int i = 0; i < 10; i++) send(3);
    wait_outs(10);
    for (int i = 0; i < 10; i++) check_got("step", i, 32'((i < 8) ? 3 * (i + 1) : 24));

    // Backpressure: history holds 3s, so 7 + 7*3 = 28
    y_ready = 1'b0;
    got.delete();
    send(7);
    n = 0;
    while (!y_valid && n < 100) begin step(); n++; end
    check("bp_valid_seen", 64'(y_valid), 1);
    y0 = y_out;
    check("bp_y", y0, 28);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold_valid", 64'(y_valid), 1);
      check("bp_hold_y", y_out, y0);
      check("bp_x_ready", 64'(x_ready), 0);
    end
    y_ready = 1'b1;
    step();
    check("bp_release_x_ready", 64'(x_ready), 1);
    check("bp_release_valid", 64'(y_valid), 0);
    check("bp_one_transfer", got.size(), 1);

    // Coefficient write while busy is ignored, in IDLE it applies
    do_reset();
    all_coef(1);
    got.delete();
    send(10);
    coef_we = 1'b1; coef_addr = '0; coef_data = 100;
    step(); step(); step();
    coef_we = 1'b0;
    wait_outs(1);
    check_got("coef_busy_ignored", 0, 10);
    wcoef(0, 100);
    send(1);
    wait_outs(2);
    check_got("coef_idle_applied", 1, 110);

    // Overflow of the N-bit output
    do_reset();
    all_coef(MAXV);
    got.delete();
    send(MAXV);
    wait_outs(1);
`ifdef FIR_SAT_EN
    check_got("overflow_sat", 0, MAXV);
`else
    check_got("overflow_wrap", 0, 1);
`endif

    // Reset mid-MAC aborts and clears history
    do_reset();
    all_coef(1);
    send(9);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_mid_valid", 64'(y_valid), 0);
    check("rst_mid_busy", 64'(busy), 0);
    all_coef(1);
    got.delete();
    send(5);
    wait_outs(1);
    check_got("rst_hist_cleared", 0, 5);

    // ena low for 5 cycles mid-MAC stretches latency only
    got.delete();
    send(4);
    step(); step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) step();
    ena = 1'b1;
    wait_outs(1);
    check_got("ena_result", 0, 9);
    check("ena_latency", lat, NTAPS + 6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      x_valid   = ($urandom_range(0, 1) == 1);
      x_in      = 32'($urandom);
      y_ready   = ($urandom_range(0, 9) < 7);
      ena       = ($urandom_range(0, 19) < 17);
      coef_we   = ($urandom_range(0, 4) == 0);
      coef_addr = 3'($urandom_range(0, NTAPS - 1));
      coef_data = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 100;
      step();
    end
    x_valid = 1'b0; y_ready = 1'b1; ena = 1'b1; coef_we = 1'b0;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    check("drain_idle", 64'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
